// File: rtl/game_ctrl_pkg.sv
// Shared encodings for the game sequencer: FSM states, move directions,
// PS/2 scan codes and the BCD increment helper.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP = 2'b00,
        DIR_DN = 2'b01,
        DIR_LT = 2'b10,
        DIR_RT = 2'b11
    } dir_t;

    localparam logic [7:0] PS2_W     = 8'h1D;
    localparam logic [7:0] PS2_S     = 8'h1B;
    localparam logic [7:0] PS2_A     = 8'h1C;
    localparam logic [7:0] PS2_D     = 8'h23;
    localparam logic [7:0] PS2_SPACE = 8'h29;
    localparam logic [7:0] PS2_P     = 8'h4D;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    localparam logic [15:0] SCORE_MAX = 16'h9999;

    // Opposite directions share the axis bit and differ only in the sense bit.
    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle of input sources and game outputs between the board/VGA side and game_ctrl.
interface game_ctrl_if;

    logic        i_btn_u;
    logic        i_btn_d;
    logic        i_btn_l;
    logic        i_btn_r;
    logic        i_btn_c;
    logic [31:0] i_keycode;
    logic        i_frame_tick;
    logic        i_hit;
    logic        i_collide;
    logic        o_move_valid;
    logic [1:0]  o_move_dir;
    logic [1:0]  o_game_state;
    logic [15:0] o_score;

    modport master (
        output i_btn_u, i_btn_d, i_btn_l, i_btn_r, i_btn_c,
        output i_keycode, i_frame_tick, i_hit, i_collide,
        input  o_move_valid, o_move_dir, o_game_state, o_score
    );

    modport slave (
        input  i_btn_u, i_btn_d, i_btn_l, i_btn_r, i_btn_c,
        input  i_keycode, i_frame_tick, i_hit, i_collide,
        output o_move_valid, o_move_dir, o_game_state, o_score
    );

endinterface

// File: rtl/game_ctrl_bcd.sv
// Four-digit BCD score counter: synchronous clear, increment, saturates at 9999.
module bcd_counter4
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_inc,
    input  logic        i_clr,
    output logic [15:0] o_count
);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != SCORE_MAX)) begin
            r_count <= bcd_inc(r_count);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: merges buttons and PS/2 keys into direction commands,
// paces moves to the frame rate, runs the game-state FSM and the score.
module game_ctrl
    import game_pkg::*;
#(
    parameter int         MOVE_DIV  = 4,
    parameter logic [7:0] KEY_UP    = PS2_W,
    parameter logic [7:0] KEY_DN    = PS2_S,
    parameter logic [7:0] KEY_LT    = PS2_A,
    parameter logic [7:0] KEY_RT    = PS2_D,
    parameter logic [7:0] KEY_GO    = PS2_SPACE,
    parameter logic [7:0] KEY_PAUSE = PS2_P
)(
    input  logic       clk,
    input  logic       reset,
    game_ctrl_if.slave bus
);

    localparam logic [3:0] DIV_LAST = 4'(MOVE_DIV - 1);

    logic [4:0]  w_btn;
    logic [4:0]  w_rise;
    logic [4:0]  r_btn_prev;
    logic [15:0] r_key_prev;
    logic [7:0]  w_code;
    logic        w_key_ev;
    logic        w_make;
    logic        w_go;
    logic        w_pause;
    logic        w_dir_ev;
    logic        w_dir_take;
    dir_t        w_dir_cand;
    state_t      r_state;
    state_t      w_state_next;
    logic        w_start;
    logic        w_run;
    logic        w_tick_move;
    logic        w_score_inc;
    logic [3:0]  r_div;
    logic        r_move_valid;
    dir_t        r_move_dir;
    dir_t        r_pend_dir;
    logic [15:0] w_score;
    logic        w_unused_key;

    // Button order is {u, d, l, r, c}; bit 4 has the highest priority.
    assign w_btn    = {bus.i_btn_u, bus.i_btn_d, bus.i_btn_l, bus.i_btn_r, bus.i_btn_c};
    assign w_rise   = w_btn & ~r_btn_prev;
    assign w_code   = bus.i_keycode[7:0];
    assign w_key_ev = (bus.i_keycode[15:0] != r_key_prev);
    assign w_make   = w_key_ev && (bus.i_keycode[15:8] != PS2_BREAK);
    assign w_go     = w_rise[0] || (w_make && (w_code == KEY_GO));
    assign w_pause  = w_make && (w_code == KEY_PAUSE);

    assign w_unused_key = ^bus.i_keycode[31:16];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_prev <= '0;
            r_key_prev <= '0;
        end else begin
            r_btn_prev <= w_btn;
            r_key_prev <= bus.i_keycode[15:0];
        end
    end

    // A button edge always beats a key in the same cycle, even if it is later rejected.
    always_comb begin
        w_dir_ev   = 1'b1;
        w_dir_cand = DIR_RT;
        if (w_rise[4]) begin
            w_dir_cand = DIR_UP;
        end else if (w_rise[3]) begin
            w_dir_cand = DIR_DN;
        end else if (w_rise[2]) begin
            w_dir_cand = DIR_LT;
        end else if (w_rise[1]) begin
            w_dir_cand = DIR_RT;
        end else if (w_make) begin
            case (w_code)
                KEY_UP:  w_dir_cand = DIR_UP;
                KEY_DN:  w_dir_cand = DIR_DN;
                KEY_LT:  w_dir_cand = DIR_LT;
                KEY_RT:  w_dir_cand = DIR_RT;
                default: w_dir_ev   = 1'b0;
            endcase
        end else begin
            w_dir_ev = 1'b0;
        end
    end

    assign w_dir_take = w_dir_ev && !is_reverse(w_dir_cand, r_move_dir);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_go) w_state_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.i_collide) begin
                    w_state_next = ST_OVER;
                end else if (w_pause) begin
                    w_state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (w_pause || w_go) w_state_next = ST_PLAY;
            end
            ST_OVER: begin
                if (w_go) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Pacing and steering only advance while the game stays in PLAY this cycle.
    assign w_start     = (r_state == ST_IDLE) && w_go;
    assign w_run       = (r_state == ST_PLAY) && (w_state_next == ST_PLAY);
    assign w_tick_move = w_run && bus.i_frame_tick && (r_div == DIV_LAST);
    assign w_score_inc = (r_state == ST_PLAY) && bus.i_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div        <= '0;
            r_move_valid <= 1'b0;
            r_move_dir   <= DIR_RT;
            r_pend_dir   <= DIR_RT;
        end else begin
            r_move_valid <= w_tick_move;
            if (w_start) begin
                r_div      <= '0;
                r_move_dir <= DIR_RT;
                r_pend_dir <= DIR_RT;
            end else if (w_run) begin
                if (w_dir_take) r_pend_dir <= w_dir_cand;
                if (w_tick_move) begin
                    r_div      <= '0;
                    r_move_dir <= r_pend_dir;
                end else if (bus.i_frame_tick) begin
                    r_div <= r_div + 4'd1;
                end
            end else if ((w_state_next == ST_IDLE) || (w_state_next == ST_OVER)) begin
                r_div <= '0;
            end
        end
    end

    bcd_counter4 u_score (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_score_inc),
        .i_clr   (w_start),
        .o_count (w_score)
    );

    assign bus.o_move_valid = r_move_valid;
    assign bus.o_move_dir   = r_move_dir;
    assign bus.o_game_state = r_state;
    assign bus.o_score      = w_score;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus random traffic
// checked every cycle against a rule-level behavioural model.
module tb_game_ctrl;

    localparam int MOVE_DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  btnLvl = '0;
    logic [31:0] keyVal = '0;

    int compareCount  = 0;
    int mismatchCount = 0;
    int moveCount     = 0;

    int          mState, mDiv, mDir, mPend, mScore;
    bit          mValid;
    logic [4:0]  mPrevBtn;
    logic [15:0] mPrevKey;

    always #5 clk = ~clk;

    game_ctrl_if bus ();

    game_ctrl #(.MOVE_DIV(MOVE_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int opposite(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int keyDir(input logic [7:0] c);
        case (c)
            8'h1D: return 0;
            8'h1B: return 1;
            8'h1C: return 2;
            8'h23: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [15:0] toBcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        if (obs !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Game rules applied to one clock edge, using the current drive values.
    task automatic modelStep(input bit rst, input bit tick, input bit hit, input bit col);
        logic [4:0] rise;
        logic [7:0] code;
        bit  make, go, pause;
        int  cand, newPend;
        if (rst) begin
            mState = 0; mDiv = 0; mValid = 0; mDir = 3; mPend = 3; mScore = 0;
            mPrevBtn = '0; mPrevKey = '0;
        end else begin
            rise  = btnLvl & ~mPrevBtn;
            code  = keyVal[7:0];
            make  = (keyVal[15:0] != mPrevKey) && (keyVal[15:8] != 8'hF0);
            go    = rise[0] || (make && code == 8'h29);
            pause = make && code == 8'h4D;
            if      (rise[4]) cand = 0;
            else if (rise[3]) cand = 1;
            else if (rise[2]) cand = 2;
            else if (rise[1]) cand = 3;
            else if (make)    cand = keyDir(code);
            else              cand = -1;
            mValid = 0;
            case (mState)
                0: if (go) begin
                    mState = 1; mScore = 0; mDiv = 0; mDir = 3; mPend = 3;
                end
                1: begin
                    if (hit && mScore < 9999) mScore++;
                    if (col) begin
                        mState = 3; mDiv = 0;
                    end else if (pause) begin
                        mState = 2;
                    end else begin
                        newPend = mPend;
                        if (cand >= 0 && cand != opposite(mDir)) newPend = cand;
                        if (tick) begin
                            if (mDiv == MOVE_DIV - 1) begin
                                mDiv = 0; mValid = 1; mDir = mPend;
                            end else begin
                                mDiv++;
                            end
                        end
                        mPend = newPend;
                    end
                end
                2: if (pause || go) mState = 1;
                default: if (go) mState = 0;
            endcase
            mPrevBtn = btnLvl;
            mPrevKey = keyVal[15:0];
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit tick, input bit hit, input bit col);
        @(negedge clk);
        reset            = rst;
        bus.i_btn_u      = btnLvl[4];
        bus.i_btn_d      = btnLvl[3];
        bus.i_btn_l      = btnLvl[2];
        bus.i_btn_r      = btnLvl[1];
        bus.i_btn_c      = btnLvl[0];
        bus.i_keycode    = keyVal;
        bus.i_frame_tick = tick;
        bus.i_hit        = hit;
        bus.i_collide    = col;
        modelStep(rst, tick, hit, col);
        @(posedge clk);
        #1;
        if (bus.o_move_valid) moveCount++;
        checkOutput("state", 32'(bus.o_game_state), 32'(mState));
        checkOutput("moveValid", 32'(bus.o_move_valid), 32'(mValid));
        checkOutput("moveDir", 32'(bus.o_move_dir), 32'(mDir));
        checkOutput("score", 32'(bus.o_score), 32'(toBcd(mScore)));
    endtask

    task automatic runToMove();
        bit seen;
        seen = 0;
        for (int i = 0; i < 4 * MOVE_DIV + 4 && !seen; i++) begin
            applyStimulus(0, 1, 0, 0);
            if (bus.o_move_valid) seen = 1;
        end
        if (!seen) checkOutput("moveTimeout", 32'd0, 32'd1);
    endtask

    task automatic pressGo();
        btnLvl = 5'b00001;
        applyStimulus(0, 0, 0, 0);
        btnLvl = 5'b00000;
        applyStimulus(0, 0, 0, 0);
    endtask

    initial begin
        logic [7:0] codes [9];
        logic [7:0] nb;
        int         idx;
        codes = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h4D, 8'hF0, 8'hF0, 8'h00};

        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("rstState", 32'(bus.o_game_state), 32'd0);
        checkOutput("rstDir", 32'(bus.o_move_dir), 32'd3);

        btnLvl = 5'b00001;
        applyStimulus(0, 0, 0, 0);
        checkOutput("startState", 32'(bus.o_game_state), 32'd1);
        checkOutput("startScore", 32'(bus.o_score), 32'h0);
        checkOutput("startDir", 32'(bus.o_move_dir), 32'd3);
        btnLvl = 5'b00000;
        applyStimulus(0, 0, 0, 0);

        moveCount = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 0, 0);
            applyStimulus(0, 0, 0, 0);
        end
        checkOutput("moveCount8", 32'(moveCount), 32'd2);

        keyVal = 32'h0000_001D;
        applyStimulus(0, 0, 0, 0);
        keyVal = 32'h0000_1D1C;
        btnLvl = 5'b01000;
        applyStimulus(0, 0, 0, 0);
        btnLvl = 5'b00000;
        runToMove();
        checkOutput("btnWinsDir", 32'(bus.o_move_dir), 32'd1);

        keyVal = 32'h0000_1C23;
        applyStimulus(0, 0, 0, 0);
        runToMove();
        checkOutput("keyRightDir", 32'(bus.o_move_dir), 32'd3);
        keyVal = 32'h0000_231C;
        applyStimulus(0, 0, 0, 0);
        runToMove();
        checkOutput("reverseIgnored", 32'(bus.o_move_dir), 32'd3);

        keyVal = 32'h0000_1CF0;
        applyStimulus(0, 0, 0, 0);
        keyVal = 32'h001C_F01D;
        applyStimulus(0, 0, 0, 0);
        runToMove();
        checkOutput("breakIgnored", 32'(bus.o_move_dir), 32'd3);

        for (int i = 0; i < 999; i++) applyStimulus(0, 0, 1, 0);
        checkOutput("score0999", 32'(bus.o_score), 32'h0999);
        applyStimulus(0, 0, 1, 0);
        checkOutput("score1000", 32'(bus.o_score), 32'h1000);

        keyVal = 32'h0000_004D;
        applyStimulus(0, 0, 0, 0);
        checkOutput("pauseState", 32'(bus.o_game_state), 32'd2);
        applyStimulus(0, 1, 1, 0);
        checkOutput("pauseHit", 32'(bus.o_score), 32'h1000);
        pressGo();
        checkOutput("resumeState", 32'(bus.o_game_state), 32'd1);

        for (int i = 0; i < 8999; i++) applyStimulus(0, 0, 1, 0);
        checkOutput("score9999", 32'(bus.o_score), 32'h9999);
        applyStimulus(0, 0, 1, 0);
        checkOutput("scoreSat", 32'(bus.o_score), 32'h9999);

        btnLvl = 5'b00001;
        applyStimulus(0, 0, 0, 1);
        checkOutput("collideWins", 32'(bus.o_game_state), 32'd3);
        btnLvl = 5'b00000;
        applyStimulus(0, 0, 0, 0);
        pressGo();
        checkOutput("overToIdle", 32'(bus.o_game_state), 32'd0);

        pressGo();
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0);
        keyVal = 32'h0000_1D1B;
        applyStimulus(1, 1, 1, 0);
        checkOutput("midRstState", 32'(bus.o_game_state), 32'd0);
        checkOutput("midRstScore", 32'(bus.o_score), 32'h0);
        checkOutput("midRstDir", 32'(bus.o_move_dir), 32'd3);
        checkOutput("midRstValid", 32'(bus.o_move_valid), 32'd0);

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int b = 0; b < 5; b++) btnLvl[b] = ($urandom_range(0, 4) == 0);
            end
            if ($urandom_range(0, 5) == 0) begin
                idx = $urandom_range(0, 9);
                nb  = (idx == 9) ? 8'($urandom) : codes[idx];
                keyVal = {keyVal[23:0], nb};
            end
            applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
